side_vram_arbiter: RTL

SIDE_VRAM_ARBITER -- requirements
Module: side_vram_arbiter

---
 rtl/side_pkg.sv | 25 ++
 rtl/side_phase_gen.sv | 42 ++++
 rtl/side_vram_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/side_pkg.sv
// side_pkg -- shared definitions for the side VRAM arbiter.
//   arb_state_t  : arbiter FSM states
//   PH_*         : tile phases at which the video fetch strobes fire
//   CPU_SLOT_DEF : default CPU access phase during active display
//   video_owned(): phases reserved for video fetch, never granted to the CPU
package side_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    localparam logic [2:0] PH_VFLG      = 3'd0;
    localparam logic [2:0] PH_VLK       = 3'd1;
    localparam logic [2:0] PH_LD_A      = 3'd3;
    localparam logic [2:0] PH_LD_B      = 3'd7;
    localparam logic [2:0] CPU_SLOT_DEF = 3'd4;

    function automatic logic video_owned(input logic [2:0] ph);
        return (ph == PH_VFLG) || (ph == PH_VLK);
    endfunction

endpackage

// File: rtl/side_phase_gen.sv
// side_phase_gen -- tile phase counter and video strobe decoder.
//   clk, rst_n : clock, synchronous active-low reset
//   ck1        : pixel clock enable
//   hld        : line-start pulse; a ck1 coinciding with it reloads phase 0
//   phase      : current tile phase (0..7)
//   vflg_en, vlk, ld_en, pix_en : one-clk strobes, coincident with ck1,
//                decoded from the phase in effect during that ck1
module side_phase_gen
    import side_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ck1,
    input  logic       hld,
    output logic [2:0] phase,
    output logic       vflg_en,
    output logic       vlk,
    output logic       ld_en,
    output logic       pix_en
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= 3'd0;
        end else if (ck1) begin
            phase <= hld ? 3'd0 : phase + 3'd1;
        end
    end

    // Strobes must coincide with ck1, so they are decoded combinationally;
    // gating with reset keeps them quiet while ck1 keeps running in reset.
    logic live;

    always_comb begin
        live    = rst_n & ck1;
        vflg_en = live && (phase == PH_VFLG);
        vlk     = live && (phase == PH_VLK);
        ld_en   = live && ((phase == PH_LD_A) || (phase == PH_LD_B));
        pix_en  = live && phase[0];
    end

endmodule

// File: rtl/side_vram_arbiter.sv
// side_vram_arbiter -- shares SRAM port 0 between video fetch and the CPU.
//   clk, VIDEO_RSTn        : clock, synchronous active-low reset
//   CK1, HLD, VBL          : pixel enable, line start, vertical blank
//   cpu_req/we/addr/wdata  : CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata     : completion pulse and read data
//   V_C                    : address mux select (1 = CPU)
//   sram_cen/we/addr/d/q   : SRAM port-0 strobes, registered address/data, read data
//   VFLG_en, VLK, LD_en, PIX_en, phase : video timing from side_phase_gen
module side_vram_arbiter
    import side_pkg::*;
#(
    parameter logic [2:0] CPU_SLOT = CPU_SLOT_DEF
) (
    input  logic        clk,
    input  logic        VIDEO_RSTn,
    input  logic        CK1,
    input  logic        HLD,
    input  logic        VBL,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [10:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  sram_q,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        V_C,
    output logic        sram_cen,
    output logic        sram_we,
    output logic [10:0] sram_addr,
    output logic [7:0]  sram_d,
    output logic        VFLG_en,
    output logic        VLK,
    output logic        LD_en,
    output logic        PIX_en,
    output logic [2:0]  phase
);

    side_phase_gen u_phase (
        .clk     (clk),
        .rst_n   (VIDEO_RSTn),
        .ck1     (CK1),
        .hld     (HLD),
        .phase   (phase),
        .vflg_en (VFLG_en),
        .vlk     (VLK),
        .ld_en   (LD_en),
        .pix_en  (PIX_en)
    );

    arb_state_t state;
    logic       we_q;
    logic [7:0] rdata_q;
    logic       grant;

    // Eligible CK1: the CPU slot during display, any phase during blank,
    // but the video fetch phases are never given away.
    assign grant = CK1 && !video_owned(phase) && (VBL || (phase == CPU_SLOT));

    always_ff @(posedge clk) begin
        if (!VIDEO_RSTn) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            sram_addr <= 11'd0;
            sram_d    <= 8'd0;
            V_C       <= 1'b0;
            sram_cen  <= 1'b0;
            sram_we   <= 1'b0;
            cpu_ack   <= 1'b0;
            rdata_q   <= 8'd0;
        end else begin
            V_C      <= 1'b0;
            sram_cen <= 1'b0;
            sram_we  <= 1'b0;
            cpu_ack  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        we_q      <= cpu_we;
                        sram_addr <= cpu_addr;
                        sram_d    <= cpu_wdata;
                        state     <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (grant) begin
                        V_C      <= 1'b1;
                        sram_cen <= 1'b1;
                        sram_we  <= we_q;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cpu_ack <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    if (!we_q) rdata_q <= sram_q;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // sram_q only becomes valid in the DONE cycle, so the ack cycle passes it
    // straight through; the register then holds it until the next ack.
    assign cpu_rdata = (state == ST_DONE && !we_q) ? sram_q : rdata_q;

endmodule
